// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt request collector and the interrupt
// controller it feeds.
//   NUM_INT_DEFAULT : default number of interrupt lines
//   addr_w()        : width of the controller's register address port
//   reg_addr_t      : register address vector for the default line count
package irq_pkg;

  localparam int NUM_INT_DEFAULT = 16;

  // One extra address bit so the controller can also address its IER
  // global-enable bit at index NUM_INT.
  function automatic int addr_w(input int n);
    return $clog2(n) + 1;
  endfunction

  typedef logic [addr_w(NUM_INT_DEFAULT)-1:0] reg_addr_t;

endpackage

// File: rtl/irq_request_collector_if.sv
// Signal bundle between the peripheral/CPU side and the IRQ request collector.
//   irq_in         : raw asynchronous interrupt lines (request = rising edge)
//   cpu_reg_access : CPU owns the controller's set/unset flags this cycle
//   overrun_clr    : one-cycle pulse clearing all overrun bits
//   ifr_set_flag   : one-cycle IFR set strobe
//   reg_addr       : line index accompanying the strobe
//   pending        : latched, not-yet-issued requests
//   overrun        : sticky lost-edge flags per line
interface irq_request_collector_if
  import irq_pkg::*;
#(
  parameter int NUM_INT = NUM_INT_DEFAULT
);

  logic [NUM_INT-1:0]         irq_in;
  logic                       cpu_reg_access;
  logic                       overrun_clr;
  logic                       ifr_set_flag;
  logic [addr_w(NUM_INT)-1:0] reg_addr;
  logic [NUM_INT-1:0]         pending;
  logic [NUM_INT-1:0]         overrun;

  // master: the surrounding system driving requests and control
  modport master (
    output irq_in, cpu_reg_access, overrun_clr,
    input  ifr_set_flag, reg_addr, pending, overrun
  );

  // slave: the collector itself
  modport slave (
    input  irq_in, cpu_reg_access, overrun_clr,
    output ifr_set_flag, reg_addr, pending, overrun
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector
//   ptr : highest-priority index this cycle
//   gnt : one-hot grant
//   idx : encoded granted index
//   vld : a grant was made
// The first set request at or above ptr wins, wrapping modulo NUM_INT.
module rr_arbiter
  import irq_pkg::*;
#(
  parameter  int NUM_INT = NUM_INT_DEFAULT,
  localparam int IDX_W   = $clog2(NUM_INT)
) (
  input  logic [NUM_INT-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_INT-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               vld
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = 0;
    for (int k = 0; k < NUM_INT; k++) begin
      // Explicit wrap keeps non-power-of-two line counts correct.
      j = int'(ptr) + k;
      if (j >= NUM_INT) j = j - NUM_INT;
      if (!vld && req[j]) begin
        vld = 1'b1;
        idx = IDX_W'(j);
      end
    end
    if (vld) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/irq_request_collector.sv
// IRQ request collector: synchronises raw peripheral IRQ lines, detects rising
// edges, latches them as pending and serialises them round-robin into
// single-cycle IFR set strobes. CPU register accesses stall the strobes.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : collector side of irq_request_collector_if (see interface header)
// SYNC_STAGES must be at least 2.
module irq_request_collector
  import irq_pkg::*;
#(
  parameter int NUM_INT     = NUM_INT_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input logic                    clk,
  input logic                    rst,
  irq_request_collector_if.slave bus
);

  localparam int ADDR_SIZE = $clog2(NUM_INT);
  localparam int CNT_W     = $clog2(SYNC_STAGES + 1);

  logic [NUM_INT-1:0]   sync_q [SYNC_STAGES];
  logic [NUM_INT-1:0]   s_q;
  logic [NUM_INT-1:0]   prev;
  logic [NUM_INT-1:0]   armed;
  logic [NUM_INT-1:0]   edge_det;
  logic [CNT_W-1:0]     fill_cnt;
  logic                 filled;

  logic [NUM_INT-1:0]   pending;
  logic [NUM_INT-1:0]   overrun;
  logic [ADDR_SIZE-1:0] rr_ptr;

  logic [NUM_INT-1:0]   grant_oh;
  logic [NUM_INT-1:0]   grant_p0;
  logic [ADDR_SIZE-1:0] grant_idx_p0;
  logic                 arb_vld;
  logic                 vld_p0;

  logic                 vld_p1;
  logic [ADDR_SIZE:0]   addr_p1;

  // ---- stage: synchroniser and edge detect ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev <= '0;
    end else begin
      sync_q[0] <= bus.irq_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= s_q;
    end
  end

  assign s_q = sync_q[SYNC_STAGES-1];

  // The synchroniser holds reset zeros for SYNC_STAGES cycles after release.
  // A line only becomes eligible for edge detection once a real low level has
  // come through, so a line held high across reset release never requests.
  assign filled = (fill_cnt == CNT_W'(SYNC_STAGES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_cnt <= '0;
      armed    <= '0;
    end else begin
      if (!filled) fill_cnt <= fill_cnt + 1'b1;
      else         armed    <= armed | ~s_q;
    end
  end

  assign edge_det = s_q & ~prev & armed;

  // ---- stage: arbitration over pending requests ----
  rr_arbiter #(
    .NUM_INT (NUM_INT)
  ) u_arb (
    .req (pending),
    .ptr (rr_ptr),
    .gnt (grant_oh),
    .idx (grant_idx_p0),
    .vld (arb_vld)
  );

  assign vld_p0   = arb_vld & ~bus.cpu_reg_access;
  assign grant_p0 = vld_p0 ? grant_oh : '0;

  // A new edge on a line being granted re-sets pending, so the fresh request
  // survives and is not counted as an overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      overrun <= '0;
      rr_ptr  <= '0;
    end else begin
      pending <= (pending & ~grant_p0) | edge_det;
      overrun <= (overrun & ~{NUM_INT{bus.overrun_clr}})
               | (edge_det & pending & ~grant_p0);
      if (vld_p0)
        rr_ptr <= (grant_idx_p0 == ADDR_SIZE'(NUM_INT - 1)) ? '0
                                                             : grant_idx_p0 + 1'b1;
    end
  end

  // ---- stage: registered strobe ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
    end else begin
      vld_p1  <= vld_p0;
      addr_p1 <= vld_p0 ? {1'b0, grant_idx_p0} : '0;
    end
  end

  assign bus.ifr_set_flag = vld_p1;
  assign bus.reg_addr     = addr_p1;
  assign bus.pending      = pending;
  assign bus.overrun      = overrun;

endmodule

// File: tb/tb_irq_request_collector.sv
// Self-checking bench for irq_request_collector: directed scenario tasks plus
// randomized traffic, all compared against a cycle-level reference model.
module tb_irq_request_collector;
  import irq_pkg::*;

  localparam int N  = 16;
  localparam int S  = 2;
  localparam int AW = addr_w(N);
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  irq_request_collector_if #(.NUM_INT(N)) bus ();

  irq_request_collector #(
    .NUM_INT     (N),
    .SYNC_STAGES (S)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: lines are seen S samples late; a line counts as a
  // request source only after a genuine low has been seen since reset.
  typedef struct packed {
    logic [N-1:0]  pend;
    logic [N-1:0]  ovr;
    logic [N-1:0]  edg;
    logic [N-1:0]  armed;
    logic [IW-1:0] ptr;
    logic          flag;
    logic [AW-1:0] addr;
  } model_t;

  model_t       m;
  logic [N-1:0] hist [$];

  function automatic model_t model_step(model_t cur, logic cpu, logic clr);
    model_t       r;
    logic [N-1:0] g;
    logic [N-1:0] vis;
    logic [N-1:0] vis_prev;
    int           n;
    int           gi;
    r  = cur;
    n  = hist.size();
    g  = '0;
    gi = -1;
    if (!cpu)
      for (int k = 0; k < N; k++)
        if (gi < 0 && cur.pend[(int'(cur.ptr) + k) % N]) gi = (int'(cur.ptr) + k) % N;
    r.flag = 1'b0;
    r.addr = '0;
    if (gi >= 0) begin
      g[gi]  = 1'b1;
      r.flag = 1'b1;
      r.addr = AW'(gi);
      r.ptr  = IW'((gi + 1) % N);
    end
    r.pend   = (cur.pend & ~g) | cur.edg;
    r.ovr    = (clr ? '0 : cur.ovr) | (cur.edg & cur.pend & ~g);
    vis      = (n >= S)     ? hist[n-S]   : '0;
    vis_prev = (n >= S + 1) ? hist[n-S-1] : '0;
    if (n >= S + 1) r.armed = cur.armed | ~vis_prev;
    r.edg = vis & ~vis_prev & r.armed;
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m <= '0;
      hist.delete();
    end else begin
      hist.push_back(bus.irq_in);
      m <= model_step(m, bus.cpu_reg_access, bus.overrun_clr);
    end
  end

  task automatic test_reset();
    bus.irq_in         = '0;
    bus.cpu_reg_access = 1'b0;
    bus.overrun_clr    = 1'b0;
    rst                = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({bus.ifr_set_flag, bus.reg_addr, bus.pending, bus.overrun} !== '0) begin
      mismatched++;
      $display("FAIL reset_state: got flag=%0b addr=%0d pend=%h ovr=%h, expected all 0",
               bus.ifr_set_flag, bus.reg_addr, bus.pending, bus.overrun);
    end
    rst = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_single();
    bus.irq_in[5] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      compared++;
      if ({bus.ifr_set_flag, bus.reg_addr, bus.pending, bus.overrun} !== {m.flag, m.addr, m.pend, m.ovr}) begin
        mismatched++;
        $display("FAIL single_model: got flag=%0b addr=%0d pend=%h ovr=%h, expected flag=%0b addr=%0d pend=%h ovr=%h",
                 bus.ifr_set_flag, bus.reg_addr, bus.pending, bus.overrun, m.flag, m.addr, m.pend, m.ovr);
      end
      compared++;
      if (bus.ifr_set_flag !== (k == 3)) begin
        mismatched++;
        $display("FAIL single_flag_c%0d: got %0b expected %0b", k, bus.ifr_set_flag, (k == 3));
      end
      if (k == 3) begin
        compared++;
        if (bus.reg_addr !== AW'(5)) begin
          mismatched++;
          $display("FAIL single_addr: got %0d expected 5", bus.reg_addr);
        end
      end
    end
    compared++;
    if (bus.pending[5] !== 1'b0 || bus.overrun !== '0) begin
      mismatched++;
      $display("FAIL single_after: got pend5=%0b ovr=%h expected pend5=0 ovr=0", bus.pending[5], bus.overrun);
    end
    bus.irq_in[5] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int got[$];
    int cyc[$];
    int exp_a[3] = '{2, 7, 15};
    // Issue line 15 alone first so the pointer wraps to 0.
    bus.irq_in[15] = 1'b1;
    repeat (5) @(negedge clk);
    bus.irq_in[15] = 1'b0;
    repeat (3) @(negedge clk);
    bus.irq_in[2] = 1'b1; bus.irq_in[7] = 1'b1; bus.irq_in[15] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      compared++;
      if ({bus.ifr_set_flag, bus.reg_addr, bus.pending, bus.overrun} !== {m.flag, m.addr, m.pend, m.ovr}) begin
        mismatched++;
        $display("FAIL simul_model: got flag=%0b addr=%0d pend=%h ovr=%h, expected flag=%0b addr=%0d pend=%h ovr=%h",
                 bus.ifr_set_flag, bus.reg_addr, bus.pending, bus.overrun, m.flag, m.addr, m.pend, m.ovr);
      end
      if (bus.ifr_set_flag) begin
        got.push_back(int'(bus.reg_addr));
        cyc.push_back(k);
      end
    end
    compared++;
    if (got.size() != 3) begin
      mismatched++;
      $display("FAIL simul_count: got %0d strobes expected 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        compared++;
        if (got[i] != exp_a[i]) begin
          mismatched++;
          $display("FAIL simul_order_%0d: got addr %0d expected %0d", i, got[i], exp_a[i]);
        end
      end
      compared++;
      if (cyc[2] - cyc[0] != 2) begin
        mismatched++;
        $display("FAIL simul_b2b: got span %0d cycles expected 2", cyc[2] - cyc[0]);
      end
    end
    bus.irq_in = '0;
    repeat (3) @(negedge clk);
    // Pointer now 0: lines 14 and 1 together must issue 1 first.
    got.delete();
    bus.irq_in[14] = 1'b1; bus.irq_in[1] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (bus.ifr_set_flag) got.push_back(int'(bus.reg_addr));
    end
    compared++;
    if (got.size() != 2 || got[0] != 1 || got[1] != 14) begin
      mismatched++;
      $display("FAIL wrap_order: got %0d strobes first=%0d expected 2 strobes 1 then 14",
               got.size(), (got.size() > 0) ? got[0] : -1);
    end
    bus.irq_in = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_fairness();
    int got[$];
    bus.irq_in[7] = 1'b1;
    repeat (5) @(negedge clk);
    bus.irq_in[7]      = 1'b0;
    bus.cpu_reg_access = 1'b1;
    bus.irq_in[3] = 1'b1; bus.irq_in[9] = 1'b1;
    repeat (4) @(negedge clk);
    bus.cpu_reg_access = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      compared++;
      if ({bus.ifr_set_flag, bus.reg_addr, bus.pending, bus.overrun} !== {m.flag, m.addr, m.pend, m.ovr}) begin
        mismatched++;
        $display("FAIL fair_model: got flag=%0b addr=%0d pend=%h ovr=%h, expected flag=%0b addr=%0d pend=%h ovr=%h",
                 bus.ifr_set_flag, bus.reg_addr, bus.pending, bus.overrun, m.flag, m.addr, m.pend, m.ovr);
      end
      if (bus.ifr_set_flag) got.push_back(int'(bus.reg_addr));
    end
    compared++;
    if (got.size() != 2 || got[0] != 9 || got[1] != 3) begin
      mismatched++;
      $display("FAIL fair_order: got %0d strobes first=%0d expected 9 then 3",
               got.size(), (got.size() > 0) ? got[0] : -1);
    end
    bus.irq_in = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_stall();
    bus.cpu_reg_access = 1'b1;
    bus.irq_in[4]      = 1'b1;
    repeat (4) @(negedge clk);
    compared++;
    if (bus.pending[4] !== 1'b1) begin
      mismatched++;
      $display("FAIL stall_pending: got %0b expected 1", bus.pending[4]);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      compared++;
      if (bus.ifr_set_flag !== 1'b0 || bus.pending[4] !== 1'b1) begin
        mismatched++;
        $display("FAIL stall_hold_c%0d: got flag=%0b pend4=%0b expected flag=0 pend4=1",
                 k, bus.ifr_set_flag, bus.pending[4]);
      end
    end
    bus.cpu_reg_access = 1'b0;
    @(negedge clk);
    compared++;
    if (bus.ifr_set_flag !== 1'b1 || bus.reg_addr !== AW'(4)) begin
      mismatched++;
      $display("FAIL stall_resume: got flag=%0b addr=%0d expected flag=1 addr=4", bus.ifr_set_flag, bus.reg_addr);
    end
    bus.irq_in = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overrun();
    int strobes = 0;
    bit hit = 0;
    bus.cpu_reg_access = 1'b1;
    for (int p = 0; p < 2; p++) begin
      bus.irq_in[1] = 1'b1; repeat (2) @(negedge clk);
      bus.irq_in[1] = 1'b0; repeat (3) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    compared++;
    if (bus.overrun[1] !== 1'b1 || bus.pending[1] !== 1'b1) begin
      mismatched++;
      $display("FAIL ovr_set: got ovr1=%0b pend1=%0b expected 1 1", bus.overrun[1], bus.pending[1]);
    end
    // Third edge: pulse overrun_clr exactly in the cycle the edge is seen.
    bus.irq_in[1] = 1'b1;
    for (int k = 0; k < 8 && !hit; k++) begin
      @(negedge clk);
      compared++;
      if ({bus.ifr_set_flag, bus.reg_addr, bus.pending, bus.overrun} !== {m.flag, m.addr, m.pend, m.ovr}) begin
        mismatched++;
        $display("FAIL ovr_model: got flag=%0b addr=%0d pend=%h ovr=%h, expected flag=%0b addr=%0d pend=%h ovr=%h",
                 bus.ifr_set_flag, bus.reg_addr, bus.pending, bus.overrun, m.flag, m.addr, m.pend, m.ovr);
      end
      if (m.edg[1]) begin
        bus.overrun_clr = 1'b1;
        hit = 1;
      end
    end
    compared++;
    if (!hit) begin
      mismatched++;
      $display("FAIL ovr_edge_timeout: got no edge on line 1 expected one within 8 cycles");
    end
    @(negedge clk);
    bus.overrun_clr = 1'b0;
    bus.irq_in[1]   = 1'b0;
    compared++;
    if (bus.overrun[1] !== 1'b1) begin
      mismatched++;
      $display("FAIL ovr_set_wins: got %0b expected 1", bus.overrun[1]);
    end
    bus.cpu_reg_access = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.ifr_set_flag && bus.reg_addr == AW'(1)) strobes++;
    end
    compared++;
    if (strobes != 1) begin
      mismatched++;
      $display("FAIL ovr_one_strobe: got %0d strobes expected 1", strobes);
    end
    bus.overrun_clr = 1'b1;
    @(negedge clk);
    bus.overrun_clr = 1'b0;
    compared++;
    if (bus.overrun[1] !== 1'b0) begin
      mismatched++;
      $display("FAIL ovr_clear: got %0b expected 0", bus.overrun[1]);
    end
  endtask

  task automatic test_edge_grant();
    int strobes = 0;
    bit hit = 0;
    bus.cpu_reg_access = 1'b1;
    bus.irq_in[6] = 1'b1; repeat (2) @(negedge clk);
    bus.irq_in[6] = 1'b0; repeat (2) @(negedge clk);
    bus.irq_in[6] = 1'b1;
    for (int k = 0; k < 10 && !hit; k++) begin
      @(negedge clk);
      compared++;
      if ({bus.ifr_set_flag, bus.reg_addr, bus.pending, bus.overrun} !== {m.flag, m.addr, m.pend, m.ovr}) begin
        mismatched++;
        $display("FAIL eg_model: got flag=%0b addr=%0d pend=%h ovr=%h, expected flag=%0b addr=%0d pend=%h ovr=%h",
                 bus.ifr_set_flag, bus.reg_addr, bus.pending, bus.overrun, m.flag, m.addr, m.pend, m.ovr);
      end
      // Release the stall so this edge cycle is also line 6's grant cycle.
      if (m.edg[6] && m.pend[6]) begin
        bus.cpu_reg_access = 1'b0;
        hit = 1;
      end
    end
    compared++;
    if (!hit) begin
      mismatched++;
      $display("FAIL eg_timeout: got no coincident edge expected one within 10 cycles");
    end
    bus.cpu_reg_access = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.ifr_set_flag && bus.reg_addr == AW'(6)) strobes++;
    end
    compared++;
    if (strobes != 2 || bus.overrun[6] !== 1'b0) begin
      mismatched++;
      $display("FAIL eg_result: got strobes=%0d ovr6=%0b expected strobes=2 ovr6=0", strobes, bus.overrun[6]);
    end
    bus.irq_in = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      compared++;
      if ({bus.ifr_set_flag, bus.reg_addr, bus.pending, bus.overrun} !== {m.flag, m.addr, m.pend, m.ovr}) begin
        mismatched++;
        $display("FAIL rand_model_c%0d: got flag=%0b addr=%0d pend=%h ovr=%h, expected flag=%0b addr=%0d pend=%h ovr=%h",
                 k, bus.ifr_set_flag, bus.reg_addr, bus.pending, bus.overrun, m.flag, m.addr, m.pend, m.ovr);
      end
      bus.irq_in         = bus.irq_in ^ (N'($urandom) & N'($urandom) & N'($urandom));
      bus.cpu_reg_access = ($urandom_range(0, 3) == 0);
      bus.overrun_clr    = ($urandom_range(0, 15) == 0);
    end
    bus.irq_in         = '0;
    bus.cpu_reg_access = 1'b0;
    bus.overrun_clr    = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int strobes = 0;
    bus.cpu_reg_access = 1'b1;
    bus.irq_in         = 16'h0f0f;
    repeat (4) @(negedge clk);
    bus.cpu_reg_access = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    compared++;
    if ({bus.ifr_set_flag, bus.reg_addr, bus.pending, bus.overrun} !== '0) begin
      mismatched++;
      $display("FAIL midreset_async: got flag=%0b addr=%0d pend=%h ovr=%h, expected all 0",
               bus.ifr_set_flag, bus.reg_addr, bus.pending, bus.overrun);
    end
    bus.irq_in = 16'h0400;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      compared++;
      if ({bus.ifr_set_flag, bus.reg_addr, bus.pending, bus.overrun} !== {m.flag, m.addr, m.pend, m.ovr}) begin
        mismatched++;
        $display("FAIL held_model: got flag=%0b addr=%0d pend=%h ovr=%h, expected flag=%0b addr=%0d pend=%h ovr=%h",
                 bus.ifr_set_flag, bus.reg_addr, bus.pending, bus.overrun, m.flag, m.addr, m.pend, m.ovr);
      end
      compared++;
      if (bus.ifr_set_flag !== 1'b0 || bus.pending !== '0) begin
        mismatched++;
        $display("FAIL held_high_c%0d: got flag=%0b pend=%h expected flag=0 pend=0", k, bus.ifr_set_flag, bus.pending);
      end
    end
    bus.irq_in = '0;
    repeat (3) @(negedge clk);
    bus.irq_in[10] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.ifr_set_flag && bus.reg_addr == AW'(10)) strobes++;
    end
    compared++;
    if (strobes != 1) begin
      mismatched++;
      $display("FAIL after_reset_edge: got %0d strobes expected 1", strobes);
    end
    bus.irq_in = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_stall();
    test_overrun();
    test_edge_grant();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
